// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared JTAG host encodings: command ops, IR opcodes, FSM states
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_DR   = 2'd0,
    OP_IR   = 2'd1,
    OP_TLR  = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_e;

  // Instruction opcodes understood by the TAP decoder on the far side.
  localparam logic [3:0] IR_SAMPLE   = 4'h1;
  localparam logic [3:0] IR_EXTEST   = 4'h2;
  localparam logic [3:0] IR_INTEST   = 4'h3;
  localparam logic [3:0] IR_RUNBIST  = 4'h4;
  localparam logic [3:0] IR_GETTEST  = 4'h5;
  localparam logic [3:0] IR_SETSTATE = 4'h6;
  localparam logic [3:0] IR_IDCODE   = 4'h7;
  localparam logic [3:0] IR_USERCODE = 4'h8;
  localparam logic [3:0] IR_BYPASS   = 4'hF;

  typedef logic [2:0] fsm_state_t;
  localparam fsm_state_t ST_RST_SEQ = 3'd0;
  localparam fsm_state_t ST_IDLE    = 3'd1;
  localparam fsm_state_t ST_PRE     = 3'd2;
  localparam fsm_state_t ST_SHIFT   = 3'd3;
  localparam fsm_state_t ST_POST    = 3'd4;
  localparam fsm_state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - TCK divider: low phase then high phase, DIV clk each
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(DIV - 1));

  // Strobes are high in the cycle whose closing edge flips TCK.
  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o      = tck_q;
  assign rise_stb_o = en_i & wrap & ~tck_q;
  assign fall_stb_o = en_i & wrap & tck_q;

endmodule

// File: rtl/jtag_host_driver.sv
// rtl/jtag_host_driver.sv - JTAG initiator turning IR/DR scan commands into TAP traffic
module jtag_host_driver #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6,
  parameter int DIV    = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i
);
  import jtag_pkg::*;

  fsm_state_t        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d, last_q, last_d, len_m1;
  cmd_op_e           op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d, cap_q, cap_d, mask_q, mask_d, rsp_q, rsp_d;
  logic              tms_q, tms_d, tdi_q, tdi_d;
  logic              tck_en, rise_stb, fall_stb;

  assign tck_en = (state_q == ST_RST_SEQ) || (state_q == ST_PRE) ||
                  (state_q == ST_SHIFT)   || (state_q == ST_POST);

  jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (tck_en),
    .tck_o      (tck_o),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // Stored as length-1 so the last-bit compare needs no arithmetic.
  always_comb begin
    if (cmd_len_i == '0)                     len_m1 = '0;
    else if (cmd_len_i > LEN_W'(DATA_W))     len_m1 = LEN_W'(DATA_W - 1);
    else                                     len_m1 = cmd_len_i - 1'b1;
  end

  function automatic logic tms_of(input fsm_state_t st, input logic [LEN_W-1:0] cnt,
                                  input logic [LEN_W-1:0] last, input cmd_op_e op);
    case (st)
      ST_RST_SEQ: tms_of = (cnt != LEN_W'(5));
      ST_PRE:     tms_of = (op == OP_IR) ? (cnt < LEN_W'(2)) : (cnt == '0);
      ST_SHIFT:   tms_of = (cnt == last);
      ST_POST:    tms_of = (cnt == '0);
      default:    tms_of = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    op_d    = op_q;
    data_d  = data_q;
    cap_d   = cap_q;
    mask_d  = mask_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_RST_SEQ: if (fall_stb) begin
        if (cnt_q == LEN_W'(5)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          rsp_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: if (cmd_valid_i) begin
        op_d   = cmd_op_e'(cmd_op_i);
        last_d = len_m1;
        data_d = cmd_data_i;
        cap_d  = '0;
        mask_d = DATA_W'(1);
        cnt_d  = '0;
        case (cmd_op_i)
          OP_DR, OP_IR: state_d = ST_PRE;
          OP_TLR:       state_d = ST_RST_SEQ;
          default: begin
            state_d = ST_DONE;
            rsp_d   = '0;
          end
        endcase
      end
      ST_PRE: if (fall_stb) begin
        if (cnt_q == ((op_q == OP_IR) ? LEN_W'(3) : LEN_W'(2))) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise_stb && tdo_i) cap_d = cap_q | mask_q;
        if (fall_stb) begin
          mask_d = mask_q << 1;
          data_d = data_q >> 1;
          if (cnt_q == last_q) begin
            state_d = ST_POST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_POST: if (fall_stb) begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          rsp_d   = cap_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_RST_SEQ;
    endcase
    // Pins are registered from next-state so they only move on TCK fall.
    tms_d = tms_of(state_d, cnt_d, last_d, op_d);
    tdi_d = (state_d == ST_SHIFT) & data_d[0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RST_SEQ;
      cnt_q   <= '0;
      last_q  <= '0;
      op_q    <= OP_TLR;
      data_q  <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_DONE);
  assign rsp_data_o  = rsp_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// tb/tb_jtag_host_driver.sv - directed bench for jtag_host_driver with a behavioural TAP
module tb_jtag_host_driver;
  import jtag_pkg::*;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;
  localparam int DIV    = 2;
  localparam logic [31:0] IDCODE_VAL = 32'h4BA0_0477;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'd0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [DATA_W-1:0] rsp_data;
  logic              tdo = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jtag_host_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV(DIV)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_len_i   (cmd_len),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .tck_o       (tck),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .tdo_i       (tdo)
  );

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_e;

  tap_e        tap_st = SHDR;
  logic [3:0]  ir = IR_IDCODE;
  logic [3:0]  ir_sr = 4'h0;
  logic [31:0] dr_sr = 32'h0;
  logic        byp = 1'b0;
  logic [7:0]  tms_hist = 8'h0;
  int          tck_cnt = 0;
  int          rsp_cnt = 0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tck_cnt++;
    tms_hist <= {tms_hist[6:0], tms};
    case (tap_st)
      TLR:   ir <= IR_IDCODE;
      CAPIR: ir_sr <= 4'b0001;
      SHIR:  ir_sr <= {tdi, ir_sr[3:1]};
      UPIR:  ir <= ir_sr;
      CAPDR: if (ir == IR_BYPASS) byp <= 1'b0;
             else dr_sr <= (ir == IR_IDCODE) ? IDCODE_VAL : 32'h0;
      SHDR:  if (ir == IR_BYPASS) byp <= tdi;
             else dr_sr <= {tdi, dr_sr[31:1]};
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    if (tap_st == SHIR)      tdo <= ir_sr[0];
    else if (tap_st == SHDR) tdo <= (ir == IR_BYPASS) ? byp : dr_sr[0];
    else                     tdo <= 1'b0;
  end

  always @(posedge clk) if (rsp_valid) rsp_cnt++;

  // Issues one command and returns at the negedge where RSP_VALID is seen.
  task automatic do_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                        input logic [DATA_W-1:0] data, output logic [DATA_W-1:0] rsp,
                        output int tcks, output int lat);
    int t0;
    bit ok;
    ok = 0; rsp = '0; tcks = -1; lat = -1;
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_ready_timeout got=%0b exp=1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    t0 = tck_cnt;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd3; cmd_len = '1; cmd_data = '1;
    for (int i = 1; i <= 2000; i++) begin
      if (rsp_valid) begin
        rsp = rsp_data; tcks = tck_cnt - t0; lat = i; ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_valid_timeout op=%0d got=0 exp=1", op);
    end
  endtask

  task automatic test_reset();
    bit seen;
    repeat (3) @(negedge clk);
    n_tests++; if ({tck, tms, tdi} !== 3'b010) begin n_fail++; $display("FAIL reset_pins got=%b exp=010", {tck, tms, tdi}); end
    n_tests++; if ({cmd_ready, rsp_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL reset_flags got=%b exp=001", {cmd_ready, rsp_valid, busy}); end
    n_tests++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL rst_seq_rsp got=0 exp=1"); end
    n_tests++; if (tck_cnt !== 6) begin n_fail++; $display("FAIL rst_seq_tck_count got=%0d exp=6", tck_cnt); end
    n_tests++; if (tms_hist[5:0] !== 6'b111110) begin n_fail++; $display("FAIL rst_seq_tms got=%b exp=111110", tms_hist[5:0]); end
    n_tests++; if (tap_st !== RTI) begin n_fail++; $display("FAIL rst_seq_tap_state got=%0d exp=%0d", tap_st, RTI); end
    @(negedge clk);
    n_tests++; if ({cmd_ready, rsp_valid, busy, tck} !== 4'b1000) begin n_fail++; $display("FAIL rst_seq_idle got=%b exp=1000", {cmd_ready, rsp_valid, busy, tck}); end
  endtask

  task automatic test_ir_scan();
    logic [DATA_W-1:0] r; int t, l;
    do_cmd(OP_IR, 6'd4, 32'h7, r, t, l);
    n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL ir_capture got=%h exp=00000001", r); end
    n_tests++; if (t !== 10) begin n_fail++; $display("FAIL ir_tck_count got=%0d exp=10", t); end
    n_tests++; if (ir !== 4'h7) begin n_fail++; $display("FAIL ir_model_value got=%h exp=7", ir); end
    n_tests++; if (tap_st !== RTI) begin n_fail++; $display("FAIL ir_end_state got=%0d exp=%0d", tap_st, RTI); end
  endtask

  task automatic test_dr_idcode();
    logic [DATA_W-1:0] r; int t, l;
    do_cmd(OP_DR, 6'd32, 32'h0, r, t, l);
    n_tests++; if (r !== IDCODE_VAL) begin n_fail++; $display("FAIL dr_idcode got=%h exp=%h", r, IDCODE_VAL); end
    n_tests++; if (t !== 37) begin n_fail++; $display("FAIL dr_tck_count got=%0d exp=37", t); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] r; int t, l;
    do_cmd(OP_IR, 6'd4, 32'hF, r, t, l);
    n_tests++; if (ir !== 4'hF) begin n_fail++; $display("FAIL bypass_ir got=%h exp=f", ir); end
    do_cmd(OP_DR, 6'd8, 32'hA5, r, t, l);
    n_tests++; if (r !== 32'h4A) begin n_fail++; $display("FAIL bypass_data got=%h exp=0000004a", r); end
    n_tests++; if (t !== 13) begin n_fail++; $display("FAIL bypass_tck_count got=%0d exp=13", t); end
  endtask

  task automatic test_len_clamp();
    logic [DATA_W-1:0] r; int t, l;
    do_cmd(OP_IR, 6'd4, 32'h7, r, t, l);
    do_cmd(OP_DR, 6'd0, 32'h0, r, t, l);
    n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL len0_data got=%h exp=00000001", r); end
    n_tests++; if (t !== 6) begin n_fail++; $display("FAIL len0_tck_count got=%0d exp=6", t); end
    do_cmd(OP_DR, 6'd40, 32'h0, r, t, l);
    n_tests++; if (r !== IDCODE_VAL) begin n_fail++; $display("FAIL len40_data got=%h exp=%h", r, IDCODE_VAL); end
    n_tests++; if (t !== 37) begin n_fail++; $display("FAIL len40_tck_count got=%0d exp=37", t); end
  endtask

  task automatic test_reserved();
    logic [DATA_W-1:0] r; int t, l;
    do_cmd(OP_RSVD, 6'd8, 32'h55, r, t, l);
    n_tests++; if (l !== 1) begin n_fail++; $display("FAIL rsvd_latency got=%0d exp=1", l); end
    n_tests++; if (t !== 0) begin n_fail++; $display("FAIL rsvd_tck_count got=%0d exp=0", t); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL rsvd_data got=%h exp=0", r); end
  endtask

  task automatic test_tap_reset();
    logic [DATA_W-1:0] r; int t, l;
    do_cmd(OP_IR, 6'd4, 32'hF, r, t, l);
    do_cmd(OP_TLR, 6'd0, 32'h0, r, t, l);
    n_tests++; if (t !== 6) begin n_fail++; $display("FAIL tlr_tck_count got=%0d exp=6", t); end
    n_tests++; if (ir !== IR_IDCODE || tap_st !== RTI) begin n_fail++; $display("FAIL tlr_model got=ir%h/st%0d exp=ir7/st%0d", ir, tap_st, RTI); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL tlr_data got=%h exp=0", r); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] r; int t, l;
    do_cmd(OP_DR, 6'd32, 32'h0, r, t, l);
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done got=%b exp=0", cmd_ready); end
    @(negedge clk);
    n_tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_after_done got=%b exp=01", {rsp_valid, cmd_ready}); end
    do_cmd(OP_DR, 6'd16, 32'h0, r, t, l);
    n_tests++; if (r !== 32'h0477) begin n_fail++; $display("FAIL b2b_second_data got=%h exp=00000477", r); end
    n_tests++; if (t !== 21) begin n_fail++; $display("FAIL b2b_tck_count got=%0d exp=21", t); end
  endtask

  task automatic test_reset_mid_scan();
    int r0;
    bit rdy;
    @(negedge clk);
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_DR; cmd_len = 6'd32; cmd_data = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && tap_st != SHDR; i++) @(negedge clk);
    n_tests++; if (tap_st !== SHDR) begin n_fail++; $display("FAIL midscan_reach_shift got=%0d exp=%0d", tap_st, SHDR); end
    repeat (10) @(negedge clk);
    r0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({tck, tms, tdi} !== 3'b010) begin n_fail++; $display("FAIL midscan_pins got=%b exp=010", {tck, tms, tdi}); end
    n_tests++; if ({cmd_ready, rsp_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL midscan_flags got=%b exp=001", {cmd_ready, rsp_valid, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_ready) begin rdy = 1; break; end
    end
    n_tests++; if (!rdy) begin n_fail++; $display("FAIL midscan_ready got=0 exp=1"); end
    n_tests++; if (rsp_cnt - r0 !== 1) begin n_fail++; $display("FAIL midscan_rsp_count got=%0d exp=1", rsp_cnt - r0); end
    n_tests++; if (tap_st !== RTI || tms_hist[5:0] !== 6'b111110) begin n_fail++; $display("FAIL midscan_rst_seq got=st%0d/tms%b exp=st%0d/tms111110", tap_st, tms_hist[5:0], RTI); end
    n_tests++; if (rsp_data !== '0) begin n_fail++; $display("FAIL midscan_rsp_data got=%h exp=0", rsp_data); end
  endtask

  initial begin
    test_reset();
    test_ir_scan();
    test_dr_idcode();
    test_bypass();
    test_len_clamp();
    test_reserved();
    test_tap_reset();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
